// File: rtl/logic_unit_pkg.sv
// Shared definitions for the logic unit: op codes, FSM state encoding and WIDTH bounds.
package logic_unit_pkg;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 8;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_NAND = 3'd1,
        OP_OR   = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_ANDN = 3'd6,
        OP_NOTA = 3'd7
    } op_e;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational bitwise function unit: y = f(a, b, op) across WIDTH bits.
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic [WIDTH-1:0] y
);

    // Select one of the eight bitwise functions
    always_comb begin
        y = {WIDTH{1'b0}};
        case (op)
            OP_AND:  y = a & b;
            OP_NAND: y = ~(a & b);
            OP_OR:   y = a | b;
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            OP_ANDN: y = a & ~b;
            OP_NOTA: y = ~a;
            default: y = {WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/logic_unit_sweep.sv
// Registered bitwise logic unit with valid/ready handshake and an exhaustive (a, b) sweep mode.
// Optional macro LOGIC_UNIT_PARITY_EN adds the registered y_par output.
module logic_unit_sweep
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             sweep_start,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             busy,
`ifdef LOGIC_UNIT_PARITY_EN
    output logic             y_par,
`endif
    output logic             sweep_done
);

    localparam int CW = 2 * WIDTH;

    state_e           state_r;
    op_e              op_lat_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] y_r;
    logic [WIDTH-1:0] out_a_r;
    logic [WIDTH-1:0] out_b_r;
    logic             out_valid_r;
    logic             sweep_done_r;

    logic             sweeping_s;
    logic             slot_free_s;
    logic             direct_fire_s;
    logic             sweep_fire_s;
    logic             load_s;
    logic             last_s;
    logic [WIDTH-1:0] core_a_s;
    logic [WIDTH-1:0] core_b_s;
    op_e              core_op_s;
    logic [WIDTH-1:0] core_y_s;

    assign sweeping_s    = (state_r == ST_SWEEP);
    assign slot_free_s   = !out_valid_r || out_ready;
    assign in_ready      = (state_r == ST_IDLE) && !sweep_start && slot_free_s;
    assign direct_fire_s = in_valid && in_ready;
    assign sweep_fire_s  = sweeping_s && slot_free_s;
    assign load_s        = direct_fire_s || sweep_fire_s;
    assign last_s        = sweep_fire_s && (&cnt_r);

    // Low half of the counter is operand A, high half is operand B
    assign core_a_s  = sweeping_s ? cnt_r[WIDTH-1:0] : a;
    assign core_b_s  = sweeping_s ? cnt_r[CW-1:WIDTH] : b;
    assign core_op_s = sweeping_s ? op_lat_r : op_e'(op);

    logic_unit_core #(.WIDTH(WIDTH)) u_core (
        .a  (core_a_s),
        .b  (core_b_s),
        .op (core_op_s),
        .y  (core_y_s)
    );

    // Sweep FSM, counter and the output register stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            op_lat_r     <= OP_AND;
            cnt_r        <= {CW{1'b0}};
            y_r          <= {WIDTH{1'b0}};
            out_a_r      <= {WIDTH{1'b0}};
            out_b_r      <= {WIDTH{1'b0}};
            out_valid_r  <= 1'b0;
            sweep_done_r <= 1'b0;
        end else begin
            sweep_done_r <= last_s;
            if (load_s) begin
                y_r         <= core_y_s;
                out_a_r     <= core_a_s;
                out_b_r     <= core_b_s;
                out_valid_r <= 1'b1;
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (sweep_start) begin
                        state_r  <= ST_SWEEP;
                        op_lat_r <= op_e'(op);
                        cnt_r    <= {CW{1'b0}};
                    end
                end
                ST_SWEEP: begin
                    // Counter wraps to zero on the all-ones vector
                    if (sweep_fire_s) begin
                        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                    if (last_s) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

`ifdef LOGIC_UNIT_PARITY_EN
    logic y_par_r;

    function automatic logic calc_parity(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    // Parity travels with y and holds under backpressure
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y_par_r <= 1'b0;
        end else if (load_s) begin
            y_par_r <= calc_parity(core_y_s);
        end else begin
            y_par_r <= y_par_r;
        end
    end

    assign y_par = y_par_r;
`endif

    assign y          = y_r;
    assign out_a      = out_a_r;
    assign out_b      = out_b_r;
    assign out_valid  = out_valid_r;
    assign busy       = sweeping_s;
    assign sweep_done = sweep_done_r;

endmodule
